// File: rtl/lc3b_types.sv
// LC-3b shared types for the MEM stage.
// Control-word fields, MEM FSM states and word helpers.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_byte;
    logic mem_indirect;
  } lc3b_control_word;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    SECOND,
    DONE
  } lc3b_mem_state;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering for MEM accesses.
// Picks lane enables, replicates store bytes, extends load bytes.
module mem_byte_lane
  import lc3b_types::*;
#(
  parameter bit SEXT_LDB = 1'b1
) (
  input  logic       lane,
  input  logic       byte_op,
  input  lc3b_word   sr2,
  input  lc3b_word   rdata,
  output logic [1:0] byte_enable,
  output lc3b_word   wdata,
  output lc3b_word   result
);

  logic [7:0] sel;

  // Word access passes through; byte access steers one lane.
  always_comb begin
    byte_enable = BE_WORD;
    wdata       = sr2;
    result      = rdata;
    sel         = lane ? rdata[15:8] : rdata[7:0];
    if (byte_op) begin
      byte_enable = lane ? BE_HI : BE_LO;
      wdata       = {sr2[7:0], sr2[7:0]};
      result      = {{8{SEXT_LDB & sel[7]}}, sel};
    end
  end

endmodule

// File: rtl/stage_mem.sv
// LC-3b MEM stage: data-memory handshake and load result.
// Holds the pipeline until each (possibly indirect) access completes.
module stage_mem
  import lc3b_types::*;
#(
  parameter bit SEXT_LDB = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_in,
  input  lc3b_control_word control_in,
  input  logic [15:0]      alu_in,
  input  logic [15:0]      sr2_in,
  input  logic             mem_resp,
  input  logic [15:0]      mem_rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [15:0]      mem_address,
  output logic [15:0]      mem_wdata,
  output logic [1:0]       mem_byte_enable,
  output logic [15:0]      mem_data_out,
  output logic             stall_out
);

  lc3b_mem_state state, state_next;
  lc3b_word      ind_addr, addr_sel;
  lc3b_word      lane_wdata, lane_result;
  logic [1:0]    lane_be;
  logic          op, first_rd;
  logic          rd_req, wr_req, byte_sel;
  logic          ind_load, data_load;

  assign op       = control_in.mem_read | control_in.mem_write;
  assign first_rd = control_in.mem_read | control_in.mem_indirect;

  mem_byte_lane #(
    .SEXT_LDB(SEXT_LDB)
  ) u_lane (
    .lane       (addr_sel[0]),
    .byte_op    (byte_sel),
    .sr2        (sr2_in),
    .rdata      (mem_rdata),
    .byte_enable(lane_be),
    .wdata      (lane_wdata),
    .result     (lane_result)
  );

  // Next state, request strobes and latch enables.
  always_comb begin
    state_next = state;
    rd_req     = 1'b0;
    wr_req     = 1'b0;
    byte_sel   = 1'b0;
    ind_load   = 1'b0;
    data_load  = 1'b0;
    addr_sel   = alu_in;
    unique case (state)
      IDLE: begin
        if (op) state_next = FIRST;
      end
      FIRST: begin
        rd_req   = first_rd;
        wr_req   = ~first_rd & control_in.mem_write;
        byte_sel = control_in.mem_byte;
        if (mem_resp) begin
          if (control_in.mem_indirect) begin
            ind_load   = 1'b1;
            state_next = SECOND;
          end else begin
            data_load  = first_rd;
            state_next = DONE;
          end
        end
      end
      SECOND: begin
        addr_sel = ind_addr;
        rd_req   = control_in.mem_read;
        wr_req   = ~control_in.mem_read & control_in.mem_write;
        if (mem_resp) begin
          data_load  = control_in.mem_read;
          state_next = DONE;
        end
      end
      DONE: begin
        if (!stall_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, indirect pointer and load result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ind_addr     <= '0;
      mem_data_out <= '0;
    end else begin
      state <= state_next;
      if (ind_load)  ind_addr     <= mem_rdata;
      if (data_load) mem_data_out <= lane_result;
    end
  end

  // Requests and stall drop the moment reset is raised.
  assign mem_read        = rd_req & ~reset;
  assign mem_write       = wr_req & ~reset;
  assign stall_out       = op & (state != DONE) & ~reset;
  assign mem_address     = {addr_sel[15:1], 1'b0};
  assign mem_wdata       = lane_wdata;
  assign mem_byte_enable = lane_be;

endmodule

// File: tb/tb_stage_mem.sv
// Bench for stage_mem: access-level memory model plus
// directed LC-3b load/store scenarios.
module tb_stage_mem;
  import lc3b_types::*;

  logic             clk = 1'b0;
  logic             reset, stall_in;
  lc3b_control_word control_in;
  logic [15:0]      alu_in, sr2_in, mem_rdata;
  logic             mem_resp;

  logic        mem_read, mem_write, stall_out;
  logic [15:0] mem_address, mem_wdata, mem_data_out;
  logic [1:0]  mem_byte_enable;

  logic        z_read, z_write, z_stall;
  logic [15:0] z_address, z_wdata, z_data_out;
  logic [1:0]  z_be;

  always #5 clk = ~clk;

  stage_mem #(.SEXT_LDB(1'b1)) dut (
    .clk(clk), .reset(reset), .stall_in(stall_in),
    .control_in(control_in), .alu_in(alu_in), .sr2_in(sr2_in),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable),
    .mem_data_out(mem_data_out), .stall_out(stall_out)
  );

  stage_mem #(.SEXT_LDB(1'b0)) dut0 (
    .clk(clk), .reset(reset), .stall_in(stall_in),
    .control_in(control_in), .alu_in(alu_in), .sr2_in(sr2_in),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .mem_read(z_read), .mem_write(z_write),
    .mem_address(z_address), .mem_wdata(z_wdata),
    .mem_byte_enable(z_be),
    .mem_data_out(z_data_out), .stall_out(z_stall)
  );

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    int          delay;
  } acc_t;

  acc_t        q[$];
  logic [15:0] mem_m [logic [15:0]];
  logic [15:0] exp_data = 16'h0000;
  logic [15:0] fin_result;
  bit          fin_load;
  int          cnt = 0;
  int          checks = 0;
  int          errors = 0;

  int          st_cyc, rq_cyc;
  logic [15:0] a_first, a_last, wd_last;
  logic [1:0]  be_last;
  logic        wr_last;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rd_m(input logic [15:0] a);
    return mem_m.exists(a) ? mem_m[a] : 16'h0000;
  endfunction

  function automatic lc3b_control_word mk(input bit r, input bit w,
                                          input bit b, input bit i);
    lc3b_control_word c;
    c.mem_read = r;
    c.mem_write = w;
    c.mem_byte = b;
    c.mem_indirect = i;
    return c;
  endfunction

  // Expected access list and final load value for one instruction.
  task automatic plan(input lc3b_control_word c, input logic [15:0] alu,
                      input logic [15:0] sr2, input int d1, input int d2);
    logic [15:0] a, p, w;
    logic [7:0]  b;
    acc_t        e;
    a = alu & 16'hFFFE;
    fin_load = c.mem_read;
    if (c.mem_indirect) begin
      e = '{0, a, 2'b11, 16'h0, d1};
      q.push_back(e);
      p = rd_m(a) & 16'hFFFE;
      if (c.mem_read) begin
        e = '{0, p, 2'b11, 16'h0, d2};
        fin_result = rd_m(p);
      end else begin
        e = '{1, p, 2'b11, sr2, d2};
      end
      q.push_back(e);
    end else if (c.mem_byte) begin
      w = rd_m(a);
      b = alu[0] ? w[15:8] : w[7:0];
      fin_result = (b >= 8'd128) ? 16'hFF00 + b : 16'h0000 + b;
      if (c.mem_read)
        e = '{0, a, alu[0] ? 2'b10 : 2'b01, 16'h0, d1};
      else
        e = '{1, a, alu[0] ? 2'b10 : 2'b01, sr2 * 16'h0101 & 16'hFFFF, d1};
      if (!c.mem_read) e.wdata = {sr2[7:0], sr2[7:0]};
      q.push_back(e);
    end else begin
      fin_result = rd_m(a);
      e = '{!c.mem_read, a, 2'b11, c.mem_read ? 16'h0 : sr2, d1};
      q.push_back(e);
    end
  endtask

  // Memory responder and per-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset) begin
      mem_resp = 1'b0;
      cnt = 0;
    end else begin
      check("data_out", mem_data_out, exp_data);
      mem_resp = 1'b0;
      mem_rdata = 16'($urandom);
      if (mem_read | mem_write) begin
        if (q.size() == 0) begin
          check("unexpected_req", {mem_read, mem_write}, 2'b00);
        end else begin
          check("req_rd", mem_read, !q[0].wr);
          check("req_wr", mem_write, q[0].wr);
          check("req_addr", mem_address, q[0].addr);
          check("req_be", mem_byte_enable, q[0].be);
          if (q[0].wr) check("req_wdata", mem_wdata, q[0].wdata);
          cnt++;
          if (cnt >= q[0].delay) begin
            mem_resp = 1'b1;
            if (q[0].wr) begin
              if (q[0].be[0]) mem_m[q[0].addr][7:0] = q[0].wdata[7:0];
              if (q[0].be[1]) mem_m[q[0].addr][15:8] = q[0].wdata[15:8];
            end else begin
              mem_rdata = rd_m(q[0].addr);
            end
            void'(q.pop_front());
            cnt = 0;
            if (q.size() == 0 && fin_load) exp_data = fin_result;
          end
        end
      end
    end
  end

  // Issue one instruction and observe it until the stage releases.
  task automatic run(input lc3b_control_word c, input logic [15:0] alu,
                     input logic [15:0] sr2, input int d1, input int d2,
                     input int hold);
    bit done;
    @(posedge clk); #1;
    control_in = c;
    alu_in = alu;
    sr2_in = sr2;
    plan(c, alu, sr2, d1, d2);
    st_cyc = 0;
    rq_cyc = 0;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (mem_read | mem_write) begin
        rq_cyc++;
        if (rq_cyc == 1) a_first = mem_address;
        a_last = mem_address;
        wd_last = mem_wdata;
        be_last = mem_byte_enable;
        wr_last = mem_write;
      end
      if (stall_out) st_cyc++;
      else done = 1;
    end
    if (!done) check("timeout", 1, 0);
    if (hold > 0) begin
      stall_in = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_stall", stall_out, 1'b0);
        check("hold_req", {mem_read, mem_write}, 2'b00);
      end
    end
    @(posedge clk); #1;
    stall_in = 1'b0;
    control_in = mk(0, 0, 0, 0);
    check("queue_empty", q.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    stall_in = 1'b0;
    control_in = mk(0, 0, 0, 0);
    alu_in = '0;
    sr2_in = '0;
    mem_resp = 1'b0;
    mem_rdata = '0;
    mem_m[16'h1002] = 16'hBEEF;
    mem_m[16'h3000] = 16'h1280;
    mem_m[16'h4000] = 16'h5000;
    mem_m[16'h5000] = 16'h1234;
    mem_m[16'h7000] = 16'h6000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read", mem_read, 1'b0);
    check("rst_write", mem_write, 1'b0);
    check("rst_stall", stall_out, 1'b0);
    check("rst_data", mem_data_out, 16'h0000);
    reset = 1'b0;

    run(mk(1, 0, 0, 0), 16'h1002, 16'h0, 2, 0, 0);
    check("ldr_addr", a_first, 16'h1002);
    check("ldr_rdcyc", rq_cyc, 2);
    check("ldr_stall", st_cyc, 3);
    check("ldr_data", mem_data_out, 16'hBEEF);

    run(mk(0, 1, 1, 0), 16'h2001, 16'h00A5, 1, 0, 0);
    check("stb_wr", wr_last, 1'b1);
    check("stb_be", be_last, 2'b10);
    check("stb_wdata", wd_last, 16'hA5A5);
    check("stb_data", mem_data_out, 16'hBEEF);

    run(mk(1, 0, 1, 0), 16'h3000, 16'h0, 1, 0, 0);
    check("ldb_sext", mem_data_out, 16'hFF80);
    check("ldb_zext", z_data_out, 16'h0080);

    run(mk(1, 0, 1, 0), 16'h3001, 16'h0, 1, 0, 0);
    check("ldb_hi_sext", mem_data_out, 16'h0012);
    check("ldb_hi_zext", z_data_out, 16'h0012);

    run(mk(1, 0, 0, 1), 16'h4000, 16'h0, 1, 1, 0);
    check("ldi_addr1", a_first, 16'h4000);
    check("ldi_addr2", a_last, 16'h5000);
    check("ldi_stall", st_cyc, 3);
    check("ldi_data", mem_data_out, 16'h1234);

    run(mk(0, 1, 0, 1), 16'h7000, 16'hCAFE, 1, 2, 0);
    check("sti_addr2", a_last, 16'h6000);
    check("sti_wr", wr_last, 1'b1);
    check("sti_wdata", wd_last, 16'hCAFE);
    check("sti_be", be_last, 2'b11);
    check("sti_stall", st_cyc, 4);
    check("sti_data", mem_data_out, 16'h1234);

    run(mk(1, 0, 0, 0), 16'h6001, 16'h0, 1, 0, 0);
    check("unal_addr", a_first, 16'h6000);
    check("unal_data", mem_data_out, 16'hCAFE);

    run(mk(0, 1, 1, 0), 16'h2000, 16'h1234, 1, 0, 0);
    check("stb_lo_be", be_last, 2'b01);
    check("stb_lo_wdata", wd_last, 16'h3434);

    @(posedge clk); #1;
    control_in = mk(0, 1, 0, 0);
    alu_in = 16'h8000;
    sr2_in = 16'h1111;
    plan(control_in, alu_in, sr2_in, 20, 0);
    @(negedge clk);
    @(negedge clk);
    check("str_pre_wr", mem_write, 1'b1);
    reset = 1'b1;
    #1;
    check("rstmid_wr", mem_write, 1'b0);
    check("rstmid_rd", mem_read, 1'b0);
    check("rstmid_stall", stall_out, 1'b0);
    q.delete();
    cnt = 0;
    exp_data = 16'h0000;
    control_in = mk(0, 0, 0, 0);
    @(posedge clk); #1;
    check("rstmid_data", mem_data_out, 16'h0000);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_wr", mem_write, 1'b0);
    end

    run(mk(1, 0, 0, 0), 16'h1002, 16'h0, 1, 0, 3);
    check("hold_data", mem_data_out, 16'hBEEF);
    check("hold_stallcyc", st_cyc, 2);
    repeat (3) @(negedge clk);
    check("idle_stall", stall_out, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
